fetch_seq_ctrl: RTL and testbench
=================================

FETCH_SEQ_CTRL -- requirements
Module: fetch_seq_ctrl

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h00000000, the first PC driven after reset.
REQ-002 SHALL have parameter MAX_WAIT, default 15, the maximum consecutive WAIT cycles before timeout.
REQ-003 SHALL have port Clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Clr  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port pc_cur  in  32  current PC from the program counter register.
REQ-006 SHALL have port imem_ready  in  1  instruction memory has data for imem_req this cycle.
REQ-007 SHALL have port hazard_stall  in  1  pipeline hazard; hold PC.
REQ-008 SHALL have port br_taken  in  1  branch/jump resolved taken this cycle.
REQ-009 SHALL have port br_target  in  32  redirect address, valid with br_taken.
REQ-010 SHALL have port halt  in  1  stop fetching.
REQ-011 SHALL have port pc_next  out  32  value for the PC register input.
REQ-012 SHALL have port pc_stall  out  1  PC register hold (1 = hold).
REQ-013 SHALL have port imem_req  out  1  fetch request at address pc_cur.
REQ-014 SHALL have port fetch_valid  out  1  fetched word accepted into the pipeline.
REQ-015 SHALL have port flush  out  1  one-cycle kill of younger in-flight instructions.
REQ-016 SHALL have port err  out  1  sticky error (timeout or misaligned target).

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, WAIT and HALT; outputs SHALL be combinational from state, registers and inputs.
REQ-018 SHALL go from IDLE to FETCH unconditionally after one cycle; in IDLE, pc_next = RESET_VEC, pc_stall = 0, imem_req = 0.
REQ-019 SHALL, in FETCH, assert imem_req = 1.
REQ-020 SHALL, in FETCH with imem_ready = 1: set fetch_valid = 1, pc_next = pc_cur + 4 (mod 2^32, wrap at 32'hFFFFFFFC to 0) and pc_stall = hazard_stall, and stay in FETCH.
REQ-021 SHALL, in FETCH with imem_ready = 0: set pc_stall = 1 and fetch_valid = 0, go to WAIT, and clear wait_cnt to 0.
REQ-022 SHALL, in WAIT: hold imem_req = 1 and pc_stall = 1, and increment wait_cnt every cycle.
REQ-023 SHALL, in WAIT with imem_ready = 1: behave as REQ-020 and return to FETCH.
REQ-024 SHALL, in WAIT, when wait_cnt reaches MAX_WAIT with imem_ready = 0: set err = 1 and go to HALT.
REQ-025 SHALL give br_taken priority over hazard_stall and sequential fetch in FETCH: pc_next = br_target, pc_stall = 0, flush = 1 for exactly that cycle, fetch_valid = 0.
REQ-026 SHALL, on br_taken in WAIT: latch br_target into redir_pc, set redir_pend = 1, and assert flush = 1 that cycle.
REQ-027 SHALL, on the subsequent imem_ready in WAIT with redir_pend = 1: discard the word (fetch_valid = 0), set pc_next = redir_pc and pc_stall = 0, clear redir_pend, and return to FETCH.
REQ-028 SHALL, on a second br_taken while redir_pend = 1: overwrite redir_pc (last redirect wins) and assert flush again.
REQ-029 SHALL, on br_taken with br_target[1:0] != 0: set err = 1, pc_stall = 1, and go to HALT with no redirect applied.
REQ-030 SHALL give halt priority over br_taken and imem_ready in any non-HALT state: pc_stall = 1, imem_req = 0, fetch_valid = 0, then go to HALT.
REQ-031 SHALL hold in HALT: pc_stall = 1, imem_req = 0, fetch_valid = 0, flush = 0; HALT SHALL be left only via Clr.
REQ-032 SHALL keep err sticky until Clr.

Reset
REQ-033 SHALL, with Clr = 1 at a rising edge: state = IDLE, wait_cnt = 0, redir_pend = 0, redir_pc = 0, err = 0.
REQ-034 SHALL, while in reset and IDLE: pc_next = RESET_VEC, pc_stall = 0, imem_req = 0, fetch_valid = 0, flush = 0.
REQ-035 SHALL let Clr override every other input in every state, including mid-WAIT with redir_pend = 1.

Verification
REQ-036 SHALL cover: reset then imem_ready tied 1, pc_cur following pc_next -> pc_next sequence 0, 4, 8, 12; fetch_valid = 1 from the first FETCH cycle.
REQ-037 SHALL cover: pc_cur = 32'h100, imem_ready low 3 cycles then high -> pc_stall = 1 for 3 cycles, then pc_next = 32'h104 with fetch_valid = 1.
REQ-038 SHALL cover: br_taken = 1 and hazard_stall = 1 together in FETCH, br_target = 32'h200 -> pc_next = 32'h200, pc_stall = 0, flush = 1 for one cycle.
REQ-039 SHALL cover: br_taken with target 32'h300 in WAIT, imem_ready two cycles later -> fetch_valid = 0, pc_next = 32'h300 on the ready cycle.
REQ-040 SHALL cover: imem_ready held 0 for MAX_WAIT+1 cycles -> err = 1, state HALT, imem_req = 0; then Clr -> err = 0, pc_next = RESET_VEC.
REQ-041 SHALL cover: br_target = 32'h202 with br_taken -> err = 1, HALT; a later halt or br_taken causes no change.

Source files
------------

// File: rtl/fetch_seq_ctrl.sv
// Instruction-fetch sequencer: drives the PC register and the imem request, handles
// memory wait states, branch redirects (deferred while waiting), halt and error trapping.
module fetch_seq_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT  = 15
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [31:0] pc_cur,
  input  logic        imem_ready,
  input  logic        hazard_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        halt,
  output logic [31:0] pc_next,
  output logic        pc_stall,
  output logic        imem_req,
  output logic        fetch_valid,
  output logic        flush,
  output logic        err
);

  localparam int CW = $clog2(MAX_WAIT + 2);
  // Last WAIT count that may still see ready; the next empty cycle is the MAX_WAIT-th.
  localparam logic [CW-1:0] TO_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_HALT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          redir_pend_q, redir_pend_d;
  logic [31:0]   redir_pc_q, redir_pc_d;
  logic          err_q, err_d;
  logic          misalign;
  logic [31:0]   seq_pc;

  assign misalign = (br_target[1:0] != 2'b00);
  assign seq_pc   = pc_cur + 32'd4;
  assign err      = err_q;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    err_d        = err_q;
    pc_next      = pc_cur;
    pc_stall     = 1'b1;
    imem_req     = 1'b0;
    fetch_valid  = 1'b0;
    flush        = 1'b0;
    case (state_q)
      S_IDLE: begin
        pc_next  = RESET_VEC;
        pc_stall = halt;
        state_d  = halt ? S_HALT : S_FETCH;
      end
      S_FETCH, S_WAIT: begin
        imem_req = !halt;
        if (halt) begin
          state_d = S_HALT;
        end else if (br_taken && misalign) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else if (br_taken && (state_q == S_FETCH || imem_ready)) begin
          pc_next      = br_target;
          pc_stall     = 1'b0;
          flush        = 1'b1;
          redir_pend_d = 1'b0;
          state_d      = S_FETCH;
        end else if (br_taken) begin
          // Memory still busy: remember the redirect, apply it when the word arrives.
          redir_pc_d   = br_target;
          redir_pend_d = 1'b1;
          flush        = 1'b1;
          wait_cnt_d   = wait_cnt_q + 1'b1;
        end else if (imem_ready) begin
          state_d      = S_FETCH;
          redir_pend_d = 1'b0;
          if (state_q == S_WAIT && redir_pend_q) begin
            pc_next  = redir_pc_q;
            pc_stall = 1'b0;
          end else begin
            fetch_valid = 1'b1;
            pc_next     = seq_pc;
            pc_stall    = hazard_stall;
          end
        end else if (state_q == S_FETCH) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end else if (wait_cnt_q >= TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (Clr) begin
      pc_next     = RESET_VEC;
      pc_stall    = 1'b0;
      imem_req    = 1'b0;
      fetch_valid = 1'b0;
      flush       = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl: an abstract per-cycle model checked on every
// negedge, plus literal expectations at the interesting points of each scenario.
module tb_fetch_seq_ctrl;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam int          MW = 15;

  logic        Clk = 1'b0;
  logic        Clr = 1'b1;
  logic [31:0] pc_cur = 32'h0;
  logic        imem_ready = 1'b0, hazard_stall = 1'b0, br_taken = 1'b0, halt = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic [31:0] pc_next;
  logic        pc_stall, imem_req, fetch_valid, flush, err;

  fetch_seq_ctrl #(.RESET_VEC(RV), .MAX_WAIT(MW)) dut (
    .Clk(Clk), .Clr(Clr), .pc_cur(pc_cur), .imem_ready(imem_ready),
    .hazard_stall(hazard_stall), .br_taken(br_taken), .br_target(br_target),
    .halt(halt), .pc_next(pc_next), .pc_stall(pc_stall), .imem_req(imem_req),
    .fetch_valid(fetch_valid), .flush(flush), .err(err)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;
  bit follow = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Abstract model: started/halted/waiting flags, count of finished WAIT cycles,
  // pending redirect and sticky error.
  bit          m_started = 0, m_halted = 0, m_wait = 0, m_pend = 0, m_err = 0;
  int          m_waited = 0;
  logic [31:0] m_rpc = 32'h0;
  bit          n_started, n_halted, n_wait, n_pend, n_err;
  int          n_waited;
  logic [31:0] n_rpc;
  logic [31:0] e_next;
  bit          e_stall, e_req, e_fv, e_fl;

  always @(negedge Clk) begin
    n_started = m_started; n_halted = m_halted; n_wait = m_wait; n_pend = m_pend;
    n_err = m_err; n_waited = m_waited; n_rpc = m_rpc;
    e_next = pc_cur; e_stall = 1; e_req = 0; e_fv = 0; e_fl = 0;
    if (Clr) begin
      e_next = RV; e_stall = 0;
    end else if (m_halted) begin
    end else if (!m_started) begin
      e_next = RV; e_stall = halt;
      if (halt) n_halted = 1; else n_started = 1;
    end else begin
      e_req = !halt;
      if (halt) n_halted = 1;
      else if (br_taken && br_target[1:0] != 2'b00) begin n_err = 1; n_halted = 1; end
      else if (br_taken && (!m_wait || imem_ready)) begin
        e_next = br_target; e_stall = 0; e_fl = 1; n_wait = 0; n_pend = 0;
      end else if (br_taken) begin
        e_fl = 1; n_pend = 1; n_rpc = br_target; n_waited = m_waited + 1;
      end else if (imem_ready && m_wait && m_pend) begin
        e_next = m_rpc; e_stall = 0; n_wait = 0; n_pend = 0;
      end else if (imem_ready) begin
        e_fv = 1; e_next = pc_cur + 32'd4; e_stall = hazard_stall; n_wait = 0; n_pend = 0;
      end else if (!m_wait) begin
        n_wait = 1; n_waited = 0;
      end else if (m_waited + 1 >= MW) begin
        n_err = 1; n_halted = 1;
      end else n_waited = m_waited + 1;
    end
    if (chk_en) begin
      chk("cmp pc_stall", {31'b0, pc_stall}, {31'b0, e_stall});
      chk("cmp imem_req", {31'b0, imem_req}, {31'b0, e_req});
      chk("cmp fetch_valid", {31'b0, fetch_valid}, {31'b0, e_fv});
      chk("cmp flush", {31'b0, flush}, {31'b0, e_fl});
      chk("cmp err", {31'b0, err}, {31'b0, m_err});
      if (!e_stall) chk("cmp pc_next", pc_next, e_next);
    end
  end

  always @(posedge Clk) begin
    if (Clr) begin
      m_started = 0; m_halted = 0; m_wait = 0; m_pend = 0; m_err = 0; m_waited = 0; m_rpc = 0;
    end else begin
      m_started = n_started; m_halted = n_halted; m_wait = n_wait; m_pend = n_pend;
      m_err = n_err; m_waited = n_waited; m_rpc = n_rpc;
    end
  end

  logic [31:0] s_next;
  logic        s_stall, s_req, s_fv, s_fl, s_err;

  task automatic step();
    @(negedge Clk);
    s_next = pc_next; s_stall = pc_stall; s_req = imem_req;
    s_fv = fetch_valid; s_fl = flush; s_err = err;
    @(posedge Clk); #1;
    if (follow && !s_stall) pc_cur = s_next;
  endtask

  task automatic reset_seq();
    Clr = 1; step(); Clr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] seq [4];
    seq[0] = 32'h0; seq[1] = 32'h4; seq[2] = 32'h8; seq[3] = 32'hC;
    @(posedge Clk); #1; chk_en = 1;
    // reset values and sequential fetch from RESET_VEC
    step();
    chk("rst pc_next", s_next, RV); chk("rst stall", {31'b0, s_stall}, 0);
    chk("rst req", {31'b0, s_req}, 0); chk("rst err", {31'b0, s_err}, 0);
    Clr = 0; imem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("seq pc_next", s_next, seq[i]);
      chk("seq fv", {31'b0, s_fv}, (i == 0) ? 32'd0 : 32'd1);
    end
    // memory wait of three cycles at 0x100
    follow = 0; pc_cur = 32'h100; imem_ready = 0;
    for (int i = 0; i < 3; i++) begin step(); chk("wait stall", {31'b0, s_stall}, 1); end
    imem_ready = 1; step();
    chk("wait pc_next", s_next, 32'h104); chk("wait fv", {31'b0, s_fv}, 1);
    // hazard alone, then branch beats hazard
    hazard_stall = 1; step();
    chk("haz stall", {31'b0, s_stall}, 1); chk("haz fv", {31'b0, s_fv}, 1);
    br_taken = 1; br_target = 32'h200; step();
    chk("br pc_next", s_next, 32'h200); chk("br stall", {31'b0, s_stall}, 0);
    chk("br flush", {31'b0, s_fl}, 1); chk("br fv", {31'b0, s_fv}, 0);
    br_taken = 0; hazard_stall = 0; step();
    chk("br flush once", {31'b0, s_fl}, 0);
    // redirect during WAIT, applied when the word arrives
    imem_ready = 0; step();
    br_taken = 1; br_target = 32'h300; step(); chk("wbr flush", {31'b0, s_fl}, 1);
    br_taken = 0; step(); chk("wbr flush off", {31'b0, s_fl}, 0);
    imem_ready = 1; step();
    chk("wbr pc_next", s_next, 32'h300); chk("wbr fv", {31'b0, s_fv}, 0);
    chk("wbr stall", {31'b0, s_stall}, 0);
    // two redirects while waiting: last one wins
    imem_ready = 0; step();
    br_taken = 1; br_target = 32'h300; step();
    br_target = 32'h340; step(); chk("wbr2 flush", {31'b0, s_fl}, 1);
    br_taken = 0; imem_ready = 1; step(); chk("wbr2 pc_next", s_next, 32'h340);
    // sequential wrap
    pc_cur = 32'hFFFF_FFFC; step(); chk("wrap pc_next", s_next, 32'h0);
    pc_cur = 32'h100;
    // MAX_WAIT empty cycles then ready: no timeout
    imem_ready = 0;
    for (int i = 0; i < MW; i++) step();
    chk("bnd req", {31'b0, s_req}, 1);
    imem_ready = 1; step();
    chk("bnd fv", {31'b0, s_fv}, 1); chk("bnd pc_next", s_next, 32'h104);
    chk("bnd err", {31'b0, s_err}, 0);
    // MAX_WAIT+1 empty cycles: timeout into HALT
    imem_ready = 0;
    for (int i = 0; i < MW + 1; i++) step();
    chk("to pre req", {31'b0, s_req}, 1); chk("to pre err", {31'b0, s_err}, 0);
    step();
    chk("to err", {31'b0, s_err}, 1); chk("to req", {31'b0, s_req}, 0);
    chk("to stall", {31'b0, s_stall}, 1);
    imem_ready = 1; step(); chk("halt fv", {31'b0, s_fv}, 0);
    reset_seq(); imem_ready = 0; step();
    chk("clr err", {31'b0, s_err}, 0); chk("clr pc_next", s_next, RV);
    // misaligned branch target
    br_taken = 1; br_target = 32'h202; step();
    chk("mis stall", {31'b0, s_stall}, 1); chk("mis flush", {31'b0, s_fl}, 0);
    br_taken = 0; step();
    chk("mis err", {31'b0, s_err}, 1); chk("mis req", {31'b0, s_req}, 0);
    halt = 1; step(); chk("mis halt stall", {31'b0, s_stall}, 1);
    halt = 0; br_taken = 1; br_target = 32'h400; step();
    chk("mis br flush", {31'b0, s_fl}, 0); chk("mis br err", {31'b0, s_err}, 1);
    br_taken = 0;
    // halt beats branch and ready
    reset_seq(); step();
    halt = 1; br_taken = 1; br_target = 32'h500; imem_ready = 1; step();
    chk("hlt stall", {31'b0, s_stall}, 1); chk("hlt req", {31'b0, s_req}, 0);
    chk("hlt flush", {31'b0, s_fl}, 0); chk("hlt fv", {31'b0, s_fv}, 0);
    halt = 0; br_taken = 0; step(); chk("hlt stays", {31'b0, s_req}, 0);
    // Clr mid-WAIT with a pending redirect
    reset_seq(); step();
    imem_ready = 0; step();
    br_taken = 1; br_target = 32'h600; step();
    br_taken = 0; Clr = 1; imem_ready = 1; step();
    chk("cw fv", {31'b0, s_fv}, 0); chk("cw req", {31'b0, s_req}, 0);
    chk("cw pc_next", s_next, RV);
    Clr = 0; step(); chk("cw idle", s_next, RV);
    step(); chk("cw seq", s_next, 32'h104); chk("cw fv2", {31'b0, s_fv}, 1);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
